// File: rtl/cu_pkg.sv
// Shared encodings for the basic-computer hardwired control unit:
// bus source codes, ALU operation codes (shared with the ALU), opcode
// values, instruction bit positions and the control-word record.
package cu_pkg;

  // Bus source selects
  typedef enum logic [2:0] {
    BUS_NONE = 3'd0,
    BUS_AR   = 3'd1,
    BUS_PC   = 3'd2,
    BUS_DR   = 3'd3,
    BUS_AC   = 3'd4,
    BUS_IR   = 3'd5,
    BUS_TR   = 3'd6,
    BUS_MEM  = 3'd7
  } bus_sel_e;

  // ALU operation codes, identical to the ALU's own decode
  typedef enum logic [2:0] {
    ALU_AND  = 3'b000,
    ALU_ADD  = 3'b001,
    ALU_XFR  = 3'b010,
    ALU_CMA  = 3'b011,
    ALU_CIR  = 3'b100,
    ALU_CIL  = 3'b101,
    ALU_INC  = 3'b110,
    ALU_PASS = 3'b111
  } alu_op_e;

  // Opcode field IR[14:12]
  localparam logic [2:0] D_AND   = 3'd0;
  localparam logic [2:0] D_ADD   = 3'd1;
  localparam logic [2:0] D_LDA   = 3'd2;
  localparam logic [2:0] D_STA   = 3'd3;
  localparam logic [2:0] D_BUN   = 3'd4;
  localparam logic [2:0] D_BSA   = 3'd5;
  localparam logic [2:0] D_ISZ   = 3'd6;
  localparam logic [2:0] D_REGIO = 3'd7;

  // Register-reference bit positions in IR[11:0]
  localparam int RR_CLA = 11;
  localparam int RR_CLE = 10;
  localparam int RR_CMA = 9;
  localparam int RR_CME = 8;
  localparam int RR_CIR = 7;
  localparam int RR_CIL = 6;
  localparam int RR_INC = 5;
  localparam int RR_SPA = 4;
  localparam int RR_SNA = 3;
  localparam int RR_SZA = 2;
  localparam int RR_SZE = 1;
  localparam int RR_HLT = 0;

  // I/O instruction bit positions that change state here
  localparam int IO_ION = 7;
  localparam int IO_IOF = 6;

  // One cycle's worth of control, plus the internal sequencing requests
  typedef struct packed {
    bus_sel_e bus;
    logic     mem_we;
    alu_op_e  alu;
    logic     rst_tr, ld_tr, inc_tr;
    logic     rst_pc, ld_pc, inc_pc;
    logic     rst_ir, ld_ir, inc_ir;
    logic     rst_dr, ld_dr, inc_dr;
    logic     rst_ar, ld_ar, inc_ar;
    logic     rst_ac, ld_ac, inc_ac;
    logic     rst_co, ld_co, inc_co;
    logic     rst_ien, inc_ien;
    logic     rst_r, inc_r;
    logic     sc_clr;
    logic     latch_i;
    logic     halt_set;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // Skip condition of the register-reference skip group; any selected
  // condition that holds causes a PC increment.
  function automatic logic reg_ref_skip(input logic [11:0] bits,
                                        input logic [15:0] ac,
                                        input logic        e);
    logic ac_zero;
    ac_zero = (ac == 16'h0000);
    return (bits[RR_SPA] & ~ac[15]) |
           (bits[RR_SNA] &  ac[15]) |
           (bits[RR_SZA] &  ac_zero) |
           (bits[RR_SZE] & ~e);
  endfunction

endpackage

// File: rtl/cu_timing_decoder.sv
// Sequence counter with clear and freeze, and its one-hot T-step decode.
// The counter never leaves the range T0..T6; an out-of-range value is
// forced back to T0.
module cu_timing_decoder #(
  parameter int SC_W = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clr_i,
  input  logic                   freeze_i,
  output logic [SC_W-1:0]        sc_o,
  output logic [(1<<SC_W)-1:0]   t_o
);

  localparam logic [SC_W-1:0] SC_LAST = SC_W'(6);

  logic [SC_W-1:0] sc_q;
  logic [SC_W-1:0] sc_d;

  // Next count: illegal values recover first, then freeze, clear, wrap, step
  always_comb begin
    sc_d = sc_q;
    if (sc_q > SC_LAST) begin
      sc_d = '0;
    end else if (freeze_i) begin
      sc_d = sc_q;
    end else if (clr_i || (sc_q == SC_LAST)) begin
      sc_d = '0;
    end else begin
      sc_d = sc_q + SC_W'(1);
    end
  end

  // Sequence counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sc_q <= '0;
    end else begin
      sc_q <= sc_d;
    end
  end

  // One-hot timing decode of the current step
  always_comb begin
    t_o       = '0;
    t_o[sc_q] = 1'b1;
  end

  assign sc_o = sc_q;

endmodule

// File: rtl/control_unit.sv
// Hardwired control unit of the basic computer. Decodes IR and the
// datapath flags into bus selects, register controls, the memory write
// strobe and the ALU op, sequencing fetch, indirect, execute, the
// interrupt cycle and halt.
module control_unit
  import cu_pkg::*;
#(
  parameter int SC_W   = 3,
  parameter int ADDR_W = 12
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [15:0]     instruction,
  input  logic [15:0]     ac_content,
  input  logic [15:0]     dr_content,
  input  logic            e_flag,
  input  logic            ien_flag,
  input  logic            r_flag,
  input  logic            irq_req,
  output logic [2:0]      bus_selects,
  output logic            write_enable,
  output logic [2:0]      op_select,
  output logic            reset_tr,
  output logic            load_tr,
  output logic            increment_tr,
  output logic            reset_pc,
  output logic            load_pc,
  output logic            increment_pc,
  output logic            reset_ir,
  output logic            load_ir,
  output logic            increment_ir,
  output logic            reset_dr,
  output logic            load_dr,
  output logic            increment_dr,
  output logic            reset_ar,
  output logic            load_ar,
  output logic            increment_ar,
  output logic            reset_ac,
  output logic            load_ac,
  output logic            increment_ac,
  output logic            reset_co,
  output logic            load_co,
  output logic            increment_co,
  output logic            write_tr,
  output logic            write_dr,
  output logic            write_ac,
  output logic            write_co,
  output logic            reset_ien,
  output logic            increment_ien,
  output logic            reset_R,
  output logic            increment_R,
  output logic [SC_W-1:0] sc_value,
  output logic            halted
);

  localparam int T_N = 1 << SC_W;

  logic            init_q, init_d;
  logic            i_q, i_d;
  logic            halt_q, halt_d;
  logic [SC_W-1:0] sc_s;
  logic [T_N-1:0]  t_s;
  logic [2:0]      d_s;
  logic [ADDR_W-1:0] rr_bits_s;
  logic            fetch_phase_s;
  logic            irq_take_s;
  ctrl_t           c;

  assign d_s           = instruction[14:12];
  assign rr_bits_s     = instruction[ADDR_W-1:0];
  assign fetch_phase_s = t_s[0] | t_s[1] | t_s[2];
  assign irq_take_s    = ~r_flag & ien_flag & irq_req & ~fetch_phase_s;

  cu_timing_decoder #(.SC_W(SC_W)) u_timing (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr_i    (c.sc_clr | init_q),
    .freeze_i (halt_q),
    .sc_o     (sc_s),
    .t_o      (t_s)
  );

  // Control word for the current step
  always_comb begin
    c = CTRL_IDLE;
    if (!reset_n) begin
      c = CTRL_IDLE;
    end else if (init_q) begin
      c.rst_pc  = 1'b1;
      c.rst_ir  = 1'b1;
      c.rst_dr  = 1'b1;
      c.rst_ar  = 1'b1;
      c.rst_ac  = 1'b1;
      c.rst_co  = 1'b1;
      c.rst_tr  = 1'b1;
      c.rst_ien = 1'b1;
      c.rst_r   = 1'b1;
    end else if (halt_q) begin
      c = CTRL_IDLE;
    end else if (r_flag && fetch_phase_s) begin
      // Interrupt cycle: save PC at M[0], vector to address 1
      case (1'b1)
        t_s[0]: begin
          c.bus    = BUS_PC;
          c.ld_tr  = 1'b1;
          c.rst_ar = 1'b1;
        end
        t_s[1]: begin
          c.bus    = BUS_TR;
          c.mem_we = 1'b1;
          c.rst_pc = 1'b1;
        end
        t_s[2]: begin
          c.inc_pc  = 1'b1;
          c.rst_ien = 1'b1;
          c.rst_r   = 1'b1;
          c.sc_clr  = 1'b1;
        end
        default: c = CTRL_IDLE;
      endcase
    end else begin
      case (1'b1)
        t_s[0]: begin
          c.bus   = BUS_PC;
          c.ld_ar = 1'b1;
        end
        t_s[1]: begin
          c.bus    = BUS_MEM;
          c.ld_ir  = 1'b1;
          c.inc_pc = 1'b1;
        end
        t_s[2]: begin
          c.bus     = BUS_IR;
          c.ld_ar   = 1'b1;
          c.latch_i = 1'b1;
        end
        t_s[3]: begin
          if (d_s == D_REGIO) begin
            c.sc_clr = 1'b1;
            if (!i_q) begin
              // Only one AC-modifying operation wins per instruction
              if (rr_bits_s[RR_CLA]) begin
                c.rst_ac = 1'b1;
              end else if (rr_bits_s[RR_CMA]) begin
                c.alu   = ALU_CMA;
                c.ld_ac = 1'b1;
              end else if (rr_bits_s[RR_CIR]) begin
                c.alu   = ALU_CIR;
                c.ld_ac = 1'b1;
                c.ld_co = 1'b1;
              end else if (rr_bits_s[RR_CIL]) begin
                c.alu   = ALU_CIL;
                c.ld_ac = 1'b1;
                c.ld_co = 1'b1;
              end else if (rr_bits_s[RR_INC]) begin
                c.inc_ac = 1'b1;
              end else begin
                c.ld_ac = 1'b0;
              end
              c.rst_co   = rr_bits_s[RR_CLE];
              c.inc_co   = rr_bits_s[RR_CME];
              c.inc_pc   = reg_ref_skip(rr_bits_s, ac_content, e_flag);
              c.halt_set = rr_bits_s[RR_HLT];
            end else begin
              c.inc_ien = rr_bits_s[IO_ION];
              c.rst_ien = rr_bits_s[IO_IOF];
            end
          end else if (i_q) begin
            c.bus   = BUS_MEM;
            c.ld_ar = 1'b1;
          end else begin
            c.sc_clr = 1'b0;
          end
        end
        t_s[4]: begin
          case (d_s)
            D_AND, D_ADD, D_LDA, D_ISZ: begin
              c.bus   = BUS_MEM;
              c.ld_dr = 1'b1;
            end
            D_STA: begin
              c.bus    = BUS_AC;
              c.mem_we = 1'b1;
              c.sc_clr = 1'b1;
            end
            D_BUN: begin
              c.bus    = BUS_AR;
              c.ld_pc  = 1'b1;
              c.sc_clr = 1'b1;
            end
            D_BSA: begin
              c.bus    = BUS_PC;
              c.mem_we = 1'b1;
              c.inc_ar = 1'b1;
            end
            default: c.sc_clr = 1'b1;
          endcase
        end
        t_s[5]: begin
          case (d_s)
            D_AND: begin
              c.alu    = ALU_AND;
              c.ld_ac  = 1'b1;
              c.sc_clr = 1'b1;
            end
            D_ADD: begin
              c.alu    = ALU_ADD;
              c.ld_ac  = 1'b1;
              c.ld_co  = 1'b1;
              c.sc_clr = 1'b1;
            end
            D_LDA: begin
              c.alu    = ALU_XFR;
              c.ld_ac  = 1'b1;
              c.sc_clr = 1'b1;
            end
            D_BSA: begin
              c.bus    = BUS_AR;
              c.ld_pc  = 1'b1;
              c.sc_clr = 1'b1;
            end
            D_ISZ: begin
              c.inc_dr = 1'b1;
            end
            default: c.sc_clr = 1'b1;
          endcase
        end
        t_s[6]: begin
          case (d_s)
            D_ISZ: begin
              c.bus    = BUS_DR;
              c.mem_we = 1'b1;
              c.inc_pc = (dr_content == 16'h0000);
              c.sc_clr = 1'b1;
            end
            default: c.sc_clr = 1'b1;
          endcase
        end
        default: c.sc_clr = 1'b1;
      endcase
      c.inc_r = irq_take_s;
    end
  end

  // Next value of the init, indirect and halt flip-flops
  always_comb begin
    init_d = 1'b0;
    if (c.latch_i) begin
      i_d = instruction[15];
    end else begin
      i_d = i_q;
    end
    halt_d = halt_q | c.halt_set;
  end

  // Init, indirect and halt flip-flops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      init_q <= 1'b1;
      i_q    <= 1'b0;
      halt_q <= 1'b0;
    end else begin
      init_q <= init_d;
      i_q    <= i_d;
      halt_q <= halt_d;
    end
  end

  assign bus_selects   = c.bus;
  assign write_enable  = c.mem_we;
  assign op_select     = c.alu;
  assign reset_tr      = c.rst_tr;
  assign load_tr       = c.ld_tr;
  assign increment_tr  = c.inc_tr;
  assign reset_pc      = c.rst_pc;
  assign load_pc       = c.ld_pc;
  assign increment_pc  = c.inc_pc;
  assign reset_ir      = c.rst_ir;
  assign load_ir       = c.ld_ir;
  assign increment_ir  = c.inc_ir;
  assign reset_dr      = c.rst_dr;
  assign load_dr       = c.ld_dr;
  assign increment_dr  = c.inc_dr;
  assign reset_ar      = c.rst_ar;
  assign load_ar       = c.ld_ar;
  assign increment_ar  = c.inc_ar;
  assign reset_ac      = c.rst_ac;
  assign load_ac       = c.ld_ac;
  assign increment_ac  = c.inc_ac;
  assign reset_co      = c.rst_co;
  assign load_co       = c.ld_co;
  assign increment_co  = c.inc_co;
  assign write_tr      = 1'b0;
  assign write_dr      = 1'b0;
  assign write_ac      = 1'b0;
  assign write_co      = 1'b0;
  assign reset_ien     = c.rst_ien;
  assign increment_ien = c.inc_ien;
  assign reset_R       = c.rst_r;
  assign increment_R   = c.inc_r;
  assign sc_value      = sc_s;
  assign halted        = halt_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed sequences, a register-reference
// vector table and a randomized run against an instruction-level model.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] instruction, ac_content, dr_content;
  logic        e_flag, ien_flag, r_flag, irq_req;
  logic [2:0]  bus_selects, op_select, sc_value;
  logic        write_enable, halted;
  logic        reset_tr, load_tr, increment_tr, reset_pc, load_pc, increment_pc;
  logic        reset_ir, load_ir, increment_ir, reset_dr, load_dr, increment_dr;
  logic        reset_ar, load_ar, increment_ar, reset_ac, load_ac, increment_ac;
  logic        reset_co, load_co, increment_co;
  logic        write_tr, write_dr, write_ac, write_co;
  logic        reset_ien, increment_ien, reset_R, increment_R;

  always #5 clk = ~clk;

  control_unit dut (
    .clk(clk), .reset_n(reset_n), .instruction(instruction),
    .ac_content(ac_content), .dr_content(dr_content), .e_flag(e_flag),
    .ien_flag(ien_flag), .r_flag(r_flag), .irq_req(irq_req),
    .bus_selects(bus_selects), .write_enable(write_enable), .op_select(op_select),
    .reset_tr(reset_tr), .load_tr(load_tr), .increment_tr(increment_tr),
    .reset_pc(reset_pc), .load_pc(load_pc), .increment_pc(increment_pc),
    .reset_ir(reset_ir), .load_ir(load_ir), .increment_ir(increment_ir),
    .reset_dr(reset_dr), .load_dr(load_dr), .increment_dr(increment_dr),
    .reset_ar(reset_ar), .load_ar(load_ar), .increment_ar(increment_ar),
    .reset_ac(reset_ac), .load_ac(load_ac), .increment_ac(increment_ac),
    .reset_co(reset_co), .load_co(load_co), .increment_co(increment_co),
    .write_tr(write_tr), .write_dr(write_dr), .write_ac(write_ac), .write_co(write_co),
    .reset_ien(reset_ien), .increment_ien(increment_ien),
    .reset_R(reset_R), .increment_R(increment_R),
    .sc_value(sc_value), .halted(halted)
  );

  // Full observable output vector
  typedef struct packed {
    logic [2:0] bus; logic we; logic [2:0] op;
    logic rtr, ltr, itr, rpc, lpc, ipc, rir, lir, iir, rdr, ldr, idr;
    logic rar, lar, iar, rac, lac, iac, rco, lco, ico;
    logic clr_ien, set_ien, clr_r, set_r;
    logic wr_any; logic [2:0] sc; logic hlt;
  } vec_t;

  vec_t obs;
  assign obs = {bus_selects, write_enable, op_select,
                reset_tr, load_tr, increment_tr, reset_pc, load_pc, increment_pc,
                reset_ir, load_ir, increment_ir, reset_dr, load_dr, increment_dr,
                reset_ar, load_ar, increment_ar, reset_ac, load_ac, increment_ac,
                reset_co, load_co, increment_co,
                reset_ien, increment_ien, reset_R, increment_R,
                (write_tr | write_dr | write_ac | write_co), sc_value, halted};

  // Register-reference / I/O slice: ipc rac lac op[2:0] lco rco ico iac iien rien
  logic [11:0] obs_rr;
  assign obs_rr = {increment_pc, reset_ac, load_ac, op_select, load_co, reset_co,
                   increment_co, increment_ac, increment_ien, reset_ien};

  typedef struct {
    logic [15:0] ins;
    logic [15:0] ac;
    logic        e;
    logic [11:0] exp;
  } rr_vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Fetch T0..T2, leaves the bench just after the edge entering T3
  task automatic fetch(input logic [15:0] ins);
    instruction = ins;
    smp();
    check("T0 sc", sc_value, 3'd0);
    check("T0 bus", bus_selects, 3'd2);
    check("T0 load_ar", load_ar, 1'b1);
    cyc(); smp();
    check("T1 bus", bus_selects, 3'd7);
    check("T1 load_ir/inc_pc", {load_ir, increment_pc}, 2'b11);
    cyc(); smp();
    check("T2 bus", bus_selects, 3'd5);
    check("T2 load_ar/no irq", {load_ar, increment_R}, 2'b10);
    cyc();
  endtask

  // ---------------- instruction-level reference model ----------------
  // Last timing step of each opcode's execution (D=7 ends at T3)
  int   last_step [8] = '{5, 5, 5, 4, 4, 5, 6, 3};
  int   m_sc;
  bit   m_i, m_halt;

  task automatic model_eval(output vec_t v, output bit done, output bit hset);
    logic [2:0]  d;
    logic [11:0] b;
    v = '0; done = 1'b0; hset = 1'b0;
    d = instruction[14:12];
    b = instruction[11:0];
    v.sc  = 3'(m_sc);
    v.hlt = m_halt;
    if (m_halt) begin
      done = 1'b0;
    end else if (r_flag && m_sc <= 2) begin
      if (m_sc == 0) begin v.bus = 3'd2; v.ltr = 1'b1; v.rar = 1'b1; end
      if (m_sc == 1) begin v.bus = 3'd6; v.we = 1'b1; v.rpc = 1'b1; end
      if (m_sc == 2) begin v.ipc = 1'b1; v.clr_ien = 1'b1; v.clr_r = 1'b1; end
      done = (m_sc == 2);
    end else begin
      done = (m_sc == last_step[d]);
      if (m_sc == 0) begin v.bus = 3'd2; v.lar = 1'b1; end
      if (m_sc == 1) begin v.bus = 3'd7; v.lir = 1'b1; v.ipc = 1'b1; end
      if (m_sc == 2) begin v.bus = 3'd5; v.lar = 1'b1; end
      if (m_sc == 3 && d != 3'd7 && m_i) begin v.bus = 3'd7; v.lar = 1'b1; end
      if (m_sc == 3 && d == 3'd7 && !m_i) begin
        if (b[11])     v.rac = 1'b1;
        else if (b[9]) begin v.op = 3'b011; v.lac = 1'b1; end
        else if (b[7]) begin v.op = 3'b100; v.lac = 1'b1; v.lco = 1'b1; end
        else if (b[6]) begin v.op = 3'b101; v.lac = 1'b1; v.lco = 1'b1; end
        else if (b[5]) v.iac = 1'b1;
        v.rco = b[10];
        v.ico = b[8];
        v.ipc = (b[4] && $signed(ac_content) >= 0) || (b[3] && $signed(ac_content) < 0) ||
                (b[2] && ac_content == 16'd0) || (b[1] && !e_flag);
        hset  = b[0];
      end
      if (m_sc == 3 && d == 3'd7 && m_i) begin
        v.set_ien = b[7];
        v.clr_ien = b[6];
      end
      if (m_sc == 4) begin
        if (d == 0 || d == 1 || d == 2 || d == 6) begin v.bus = 3'd7; v.ldr = 1'b1; end
        if (d == 3) begin v.bus = 3'd4; v.we = 1'b1; end
        if (d == 4) begin v.bus = 3'd1; v.lpc = 1'b1; end
        if (d == 5) begin v.bus = 3'd2; v.we = 1'b1; v.iar = 1'b1; end
      end
      if (m_sc == 5) begin
        if (d <= 2) begin v.op = d; v.lac = 1'b1; v.lco = (d == 1); end
        if (d == 5) begin v.bus = 3'd1; v.lpc = 1'b1; end
        if (d == 6) v.idr = 1'b1;
      end
      if (m_sc == 6) begin
        v.bus = 3'd3; v.we = 1'b1; v.ipc = (dr_content == 16'd0);
      end
      v.set_r = !r_flag && ien_flag && irq_req && m_sc >= 3;
    end
  endtask

  rr_vec_t rr_tab [20];

  initial begin
    vec_t        ev;
    bit          done, hset;
    logic [15:0] ins;

    rr_tab = '{
      '{16'h7800, 16'h1234, 1'b0, 12'h400},   // CLA
      '{16'h7400, 16'h1234, 1'b0, 12'h010},   // CLE
      '{16'h7200, 16'h1234, 1'b0, 12'h2C0},   // CMA
      '{16'h7100, 16'h1234, 1'b0, 12'h008},   // CME
      '{16'h7080, 16'h1234, 1'b0, 12'h320},   // CIR
      '{16'h7040, 16'h1234, 1'b0, 12'h360},   // CIL
      '{16'h7020, 16'h1234, 1'b0, 12'h004},   // INC
      '{16'h7010, 16'h0000, 1'b1, 12'h800},   // SPA, AC=0 skips
      '{16'h7010, 16'h8000, 1'b1, 12'h000},   // SPA, AC negative
      '{16'h7008, 16'h8000, 1'b1, 12'h800},   // SNA
      '{16'h7008, 16'h0005, 1'b1, 12'h000},   // SNA, AC positive
      '{16'h7004, 16'h0001, 1'b1, 12'h000},   // SZA, AC nonzero
      '{16'h7004, 16'h0000, 1'b1, 12'h800},   // SZA
      '{16'h7002, 16'h1234, 1'b0, 12'h800},   // SZE, E=0
      '{16'h7002, 16'h1234, 1'b1, 12'h000},   // SZE, E=1
      '{16'h7220, 16'h1234, 1'b0, 12'h2C0},   // CMA beats INC
      '{16'h70C0, 16'h1234, 1'b0, 12'h320},   // CIR beats CIL
      '{16'h7D00, 16'h1234, 1'b0, 12'h418},   // CLA+CLE+CME
      '{16'hF080, 16'h1234, 1'b0, 12'h002},   // ION
      '{16'hF040, 16'h1234, 1'b0, 12'h001}    // IOF
    };

    reset_n = 1'b0; instruction = 16'h0000; ac_content = 16'h0000; dr_content = 16'h0000;
    e_flag = 1'b0; ien_flag = 1'b0; r_flag = 1'b0; irq_req = 1'b0;

    // Reset held: everything quiet
    smp(); smp();
    check("reset outputs", obs, 40'd0);
    cyc();
    reset_n = 1'b1;
    smp();
    ev = '0;
    ev.rtr = 1'b1; ev.rpc = 1'b1; ev.rir = 1'b1; ev.rdr = 1'b1; ev.rar = 1'b1;
    ev.rac = 1'b1; ev.rco = 1'b1; ev.clr_ien = 1'b1; ev.clr_r = 1'b1;
    check("init cycle", obs, 40'(ev));
    cyc();

    // LDA direct
    fetch(16'h2005);
    smp();
    check("LDA T3 idle", {sc_value, bus_selects, load_ar}, {3'd3, 3'd0, 1'b0});
    cyc(); smp();
    check("LDA T4", {bus_selects, load_dr}, {3'd7, 1'b1});
    cyc(); smp();
    check("LDA T5", {op_select, load_ac, load_co}, {3'b010, 1'b1, 1'b0});
    cyc();

    // LDA indirect
    fetch(16'hA005);
    smp();
    check("LDA-I T3", {bus_selects, load_ar}, {3'd7, 1'b1});
    cyc(); smp();
    check("LDA-I T4", {bus_selects, load_dr}, {3'd7, 1'b1});
    cyc(); smp();
    check("LDA-I T5", {op_select, load_ac}, {3'b010, 1'b1});
    cyc();

    // ISZ with DR reaching zero, then not
    for (int k = 0; k < 2; k++) begin
      dr_content = (k == 0) ? 16'h0000 : 16'h0001;
      fetch(16'h6010);
      cyc(); smp();
      check("ISZ T4", {bus_selects, load_dr}, {3'd7, 1'b1});
      cyc(); smp();
      check("ISZ T5", increment_dr, 1'b1);
      cyc(); smp();
      check("ISZ T6", {sc_value, bus_selects, write_enable, increment_pc},
            {3'd6, 3'd3, 1'b1, (k == 0) ? 1'b1 : 1'b0});
      cyc();
    end

    // Register-reference / I/O vector table
    for (int k = 0; k < 20; k++) begin
      ac_content = rr_tab[k].ac;
      e_flag     = rr_tab[k].e;
      fetch(rr_tab[k].ins);
      smp();
      check($sformatf("regref %04h", rr_tab[k].ins), obs_rr, 40'(rr_tab[k].exp));
      cyc();
    end

    // Interrupt request during BUN, then the interrupt cycle
    ien_flag = 1'b1; irq_req = 1'b1;
    fetch(16'h4005);
    smp();
    check("irq at T3", increment_R, 1'b1);
    cyc(); smp();
    check("BUN T4 + irq", {bus_selects, load_pc, increment_R}, {3'd1, 1'b1, 1'b1});
    cyc();
    r_flag = 1'b1; irq_req = 1'b0;
    smp();
    check("int T0", {sc_value, bus_selects, load_tr, reset_ar, load_ar}, {3'd0, 3'd2, 1'b1, 1'b1, 1'b0});
    cyc(); smp();
    check("int T1", {bus_selects, write_enable, reset_pc}, {3'd6, 1'b1, 1'b1});
    cyc(); smp();
    check("int T2", {increment_pc, reset_ien, reset_R, increment_R}, 4'b1110);
    cyc();
    r_flag = 1'b0; ien_flag = 1'b0;

    // HLT: outputs quiet and SC frozen until reset_n pulses
    fetch(16'h7001);
    smp();
    check("HLT T3 not yet halted", halted, 1'b0);
    cyc();
    ev = '0; ev.hlt = 1'b1;
    for (int k = 0; k < 3; k++) begin
      smp();
      check("halted frozen", obs, 40'(ev));
      cyc();
    end
    reset_n = 1'b0;
    smp();
    check("halt cleared by reset", obs, 40'd0);
    cyc();
    reset_n = 1'b1;
    cyc();
    ac_content = 16'h0000; e_flag = 1'b0;
    fetch(16'h7020);
    smp();
    check("after halt INC", increment_ac, 1'b1);
    cyc();

    // Randomized run against the model
    m_sc = 0; m_i = 1'b0; m_halt = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (m_sc == 0) begin
        ins = 16'($urandom);
        if (ins[14:12] == 3'd7 && !ins[15]) ins[0] = 1'b0;
        instruction = ins;
        r_flag = ($urandom_range(0, 5) == 0);
      end
      case ($urandom_range(0, 3))
        0:       ac_content = 16'h0000;
        1:       ac_content = 16'h8000 | 16'($urandom);
        default: ac_content = 16'($urandom);
      endcase
      dr_content = ($urandom_range(0, 2) == 0) ? 16'h0000 : 16'($urandom);
      e_flag   = 1'($urandom);
      ien_flag = 1'($urandom);
      irq_req  = 1'($urandom);
      smp();
      model_eval(ev, done, hset);
      check($sformatf("random cycle %0d", n), obs, 40'(ev));
      if (!m_halt) begin
        if (m_sc == 2 && !r_flag) m_i = instruction[15];
        if (hset) m_halt = 1'b1;
        m_sc = done ? 0 : m_sc + 1;
      end
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
